mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and load/store units
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t              state, state_nx;
  logic                last_lsu, owner_lsu, gnt_ifu, gnt_lsu;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  // grant only in IDLE; on a tie the requester not served last wins
  always_comb begin
    gnt_ifu = state == IDLE && ifu_req_valid && (!lsu_req_valid || last_lsu);
    gnt_lsu = state == IDLE && lsu_req_valid && !gnt_ifu;
  end
  // next-state: one transaction walks IDLE -> REQ -> RESP -> IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (gnt_ifu || gnt_lsu) ? REQ : IDLE;
      REQ:     state_nx = mem_req_ready ? RESP : REQ;
      RESP:    state_nx = mem_resp_valid ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // outputs: latched request shown only while requesting, response forwarded only in RESP
  always_comb begin
    ifu_req_ready  = gnt_ifu;
    lsu_req_ready  = gnt_lsu;
    mem_req_valid  = state == REQ;
    mem_addr       = mem_req_valid ? addr_q : '0;
    mem_wen        = mem_req_valid && wen_q;
    mem_wdata      = mem_req_valid ? wdata_q : '0;
    mem_wmask      = mem_req_valid ? wmask_q : '0;
    ifu_resp_valid = state == RESP && mem_resp_valid && !owner_lsu;
    lsu_resp_valid = state == RESP && mem_resp_valid && owner_lsu;
    resp_rdata     = (ifu_resp_valid || lsu_resp_valid) ? mem_rdata : '0;
  end
  // state register and request latch; requester inputs captured only on the grant cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_lsu  <= 1'b1;
      owner_lsu <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      state <= state_nx;
      if (gnt_ifu || gnt_lsu) begin
        last_lsu  <= gnt_lsu;
        owner_lsu <= gnt_lsu;
        addr_q    <= gnt_lsu ? lsu_addr : ifu_addr;
        wen_q     <= gnt_lsu && lsu_wen;
        wdata_q   <= gnt_lsu ? lsu_wdata : '0;
        wmask_q   <= gnt_lsu ? lsu_wmask : '0;
      end
    end
  end
endmodule
